// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory interface: responder FSM states, MMIO
// register offsets and the DMType codes the requester uses for load extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] MMIO_LED   = 32'h0000_0000;
    localparam logic [31:0] MMIO_CYCLE = 32'h0000_0004;

    // Access size/sign codes; the responder always returns the raw word.
    typedef enum logic [2:0] {
        dm_b  = 3'd0,
        dm_h  = 3'd1,
        dm_w  = 3'd2,
        dm_bu = 3'd4,
        dm_hu = 3'd5
    } dmtype_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage with per-byte write enables and a registered,
// enable-gated read port (read data holds until the next enabled read).
module dmem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: single outstanding request, word array with fixed access
// latency, and an MMIO window holding the LED register and a free-running cycle counter.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wea,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] led
);

    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [3:0]    wea_q, wea_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [15:0]   led_q, led_d;
    logic [31:0]   cyc_q, cyc_d;

    logic          in_mmio, in_array, busy_done;
    logic [31:0]   mmio_off, mmio_word, arr_rdata;
    logic [3:0]    arr_be;
    logic [1:0]    unused_off;

    assign in_mmio    = (req_addr >= MMIO_BASE);
    assign in_array   = !in_mmio && ({2'b00, req_addr[31:2]} < 32'(DEPTH));
    assign mmio_off   = req_addr - MMIO_BASE;
    assign mmio_word  = {mmio_off[31:2], 2'b00};
    assign unused_off = mmio_off[1:0];
    assign busy_done  = (state_q == ST_BUSY) && (lat_q == LAT_LAST);

    // Gated by rst so a reset landing on the BUSY->RESP edge abandons the store.
    assign arr_be = (busy_done && !rst) ? wea_q : 4'b0000;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rd_en   (req_valid && req_ready && in_array),
        .rd_addr (req_addr[AW+1:2]),
        .rd_data (arr_rdata),
        .wr_be   (arr_be),
        .wr_addr (waddr_q),
        .wr_data (wdata_q)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        waddr_d = waddr_q;
        wea_d   = wea_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        led_d   = led_q;
        cyc_d   = cyc_q + 32'd1;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    waddr_d = req_addr[AW+1:2];
                    wea_d   = req_wea;
                    wdata_d = req_wdata;
                    lat_d   = '0;
                    if (in_array) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_RESP;
                        rdata_d = 32'd0;
                        err_d   = 1'b0;
                        if (!in_mmio) begin
                            err_d = 1'b1;
                        end else if (mmio_word == MMIO_LED) begin
                            rdata_d = {16'h0000, led_q};
                            if (req_wea[0]) led_d[7:0]  = req_wdata[7:0];
                            if (req_wea[1]) led_d[15:8] = req_wdata[15:8];
                        end else if (mmio_word == MMIO_CYCLE) begin
                            rdata_d = cyc_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (busy_done) begin
                    state_d = ST_RESP;
                    rdata_d = arr_rdata;
                    err_d   = 1'b0;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            waddr_q <= '0;
            wea_q   <= 4'b0000;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            led_q   <= 16'h0000;
            cyc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            waddr_q <= waddr_d;
            wea_q   <= wea_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            led_q   <= led_d;
            cyc_q   <= cyc_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign led       = led_q;

endmodule
